// File: rtl/mem_access_unit.sv
// Data-memory initiator for the single-cycle CPU: word-aligned reads and writes,
// read-modify-write for sub-word stores, big-endian lane extraction and extension.
module mem_access_unit #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       MemReadData
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t      state;
    logic        weR;
    logic [1:0]  sizeR;
    logic        unsR;
    logic [1:0]  offR;
    logic [15:0] wdR;

    logic        reqBad;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    // Rejected requests never reach memory; they go straight to RESP with err.
    always_comb begin
        reqBad = (req_size == SIZE_BAD)
              || (req_size == SIZE_HALF && req_addr[0])
              || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
              || (req_addr >= MEM_LIMIT);
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        laneByte   = 8'h00;
        loadValue  = MemReadData;
        mergedWord = MemReadData;

        case (offR)
            2'd0:    laneByte = MemReadData[31:24];
            2'd1:    laneByte = MemReadData[23:16];
            2'd2:    laneByte = MemReadData[15:8];
            default: laneByte = MemReadData[7:0];
        endcase
        laneHalf = offR[1] ? MemReadData[15:0] : MemReadData[31:16];

        case (sizeR)
            SIZE_BYTE: loadValue = unsR ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
            SIZE_HALF: loadValue = unsR ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
            default:   loadValue = MemReadData;
        endcase

        // Only the addressed lane is replaced; the other bytes pass through unchanged.
        case (sizeR)
            SIZE_BYTE: begin
                case (offR)
                    2'd0:    mergedWord[31:24] = wdR[7:0];
                    2'd1:    mergedWord[23:16] = wdR[7:0];
                    2'd2:    mergedWord[15:8]  = wdR[7:0];
                    default: mergedWord[7:0]   = wdR[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offR[1]) mergedWord[15:0]  = wdR;
                else         mergedWord[31:16] = wdR;
            end
            default: mergedWord = MemReadData;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= 32'h0;
            MemAddr      <= '0;
            MemWriteData <= 32'h0;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            weR          <= 1'b0;
            sizeR        <= 2'b00;
            unsR         <= 1'b0;
            offR         <= 2'b00;
            wdR          <= 16'h0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        weR   <= req_we;
                        sizeR <= req_size;
                        unsR  <= req_unsigned;
                        offR  <= req_addr[1:0];
                        wdR   <= req_wdata[15:0];
                        busy  <= 1'b1;
                        if (reqBad) begin
                            state <= RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (req_we && req_size == SIZE_WORD) begin
                            state        <= WR;
                            MemAddr      <= {req_addr[ADDR_W-1:2], 2'b00};
                            MemWriteData <= req_wdata;
                            MemWrite     <= 1'b1;
                        end else begin
                            state   <= RD;
                            MemAddr <= {req_addr[ADDR_W-1:2], 2'b00};
                            MemRead <= 1'b1;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (weR) begin
                        state        <= WR;
                        MemWriteData <= mergedWord;
                        MemWrite     <= 1'b1;
                    end else begin
                        state <= RESP;
                        rdata <= loadValue;
                        done  <= 1'b1;
                    end
                end
                WR: begin
                    state <= RESP;
                    done  <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 128-byte big-endian memory model
// that registers read data one cycle after MemRead.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    int nCmp = 0;
    int nBad = 0;

    logic [31:0] mem [0:31];
    int          rdCount   = 0;
    int          wrCount   = 0;
    int          bothCount = 0;
    logic [31:0] lastRdAddr = 32'h0;
    logic [31:0] lastWrAddr = 32'h0;
    logic [31:0] lastWrData = 32'h0;

    mem_access_unit #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        MemReadData = 32'h0;
    end

    always @(posedge clk) begin
        if (MemRead) begin
            MemReadData <= mem[MemAddr[6:2]];
            rdCount     <= rdCount + 1;
            lastRdAddr  <= MemAddr;
        end
        if (MemWrite) begin
            mem[MemAddr[6:2]] <= MemWriteData;
            wrCount           <= wrCount + 1;
            lastWrAddr        <= MemAddr;
            lastWrData        <= MemWriteData;
        end
        if (MemRead && MemWrite) bothCount <= bothCount + 1;
    end

    // Issues one request and reports the cycle (accept edge = 0) in which done was seen.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int cyc, output logic e, output logic [31:0] rd);
        @(negedge clk);
        req = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        cyc = 0; e = 1'b0; rd = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i; e = err; rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        nCmp++;
        if ({busy, done, err, MemRead, MemWrite} !== 5'b0 || rdata !== 32'h0
            || MemAddr !== 32'h0 || MemWriteData !== 32'h0) begin
            nBad++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want all zero",
                     busy, done, err, MemRead, MemWrite, rdata, MemAddr, MemWriteData);
        end
        rst = 1'b0;
    endtask

    task automatic test_word_store_load();
        int cyc; logic e; logic [31:0] rd; int r0, w0;
        r0 = rdCount; w0 = wrCount;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hA1B2C3D4, cyc, e, rd);
        nCmp++;
        if (cyc !== 2 || e !== 1'b0 || rd !== 32'h0) begin
            nBad++;
            $display("FAIL sw_done: got cyc=%0d err=%b rdata=%h want cyc=2 err=0 rdata=00000000", cyc, e, rd);
        end
        nCmp++;
        if (wrCount - w0 != 1 || rdCount - r0 != 0 || lastWrAddr !== 32'h20 || lastWrData !== 32'hA1B2C3D4) begin
            nBad++;
            $display("FAIL sw_bus: got writes=%0d reads=%0d addr=%h data=%h want 1 0 00000020 a1b2c3d4",
                     wrCount - w0, rdCount - r0, lastWrAddr, lastWrData);
        end
        r0 = rdCount; w0 = wrCount;
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, cyc, e, rd);
        nCmp++;
        if (cyc !== 3 || e !== 1'b0 || rd !== 32'hA1B2C3D4 || rdCount - r0 != 1 || wrCount - w0 != 0) begin
            nBad++;
            $display("FAIL lw_0x20: got cyc=%0d err=%b rdata=%h reads=%0d writes=%0d want 3 0 a1b2c3d4 1 0",
                     cyc, e, rd, rdCount - r0, wrCount - w0);
        end
    endtask

    task automatic test_subword_loads();
        int cyc; logic e; logic [31:0] rd;
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad  [4] = '{32'h21, 32'h21, 32'h22, 32'h20};
        logic [31:0] exp [4] = '{32'hFFFFFFB2, 32'h000000B2, 32'hFFFFC3D4, 32'h0000A1B2};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, cyc, e, rd);
            nCmp++;
            if (cyc !== 3 || e !== 1'b0 || rd !== exp[i]) begin
                nBad++;
                $display("FAIL subload_%0d: got cyc=%0d err=%b rdata=%h want 3 0 %h", i, cyc, e, rd, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        int cyc; logic e; logic [31:0] rd; int r0, w0;
        logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h21, 32'h23, 32'h00, 32'h80};
        for (int i = 0; i < 4; i++) begin
            r0 = rdCount; w0 = wrCount;
            do_req(we[i], sz[i], 1'b0, ad[i], 32'hDEADBEEF, cyc, e, rd);
            nCmp++;
            if (cyc !== 1 || e !== 1'b1 || rd !== 32'h0000A1B2 || rdCount != r0 || wrCount != w0) begin
                nBad++;
                $display("FAIL error_%0d: got cyc=%0d err=%b rdata=%h reads=%0d writes=%0d want 1 1 0000a1b2 0 0",
                         i, cyc, e, rd, rdCount - r0, wrCount - w0);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; int r0, w0;
        r0 = rdCount; w0 = wrCount; cyc = 0;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_addr = 32'h44; req_we = 1'b1; req_wdata = 32'h55555555;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin cyc = i; break; end
        end
        req = 1'b0;
        nCmp++;
        if (cyc !== 3 || err !== 1'b0 || rdata !== 32'hA1B2C3D4 || rdCount - r0 != 1
            || wrCount != w0 || lastRdAddr !== 32'h20) begin
            nBad++;
            $display("FAIL busy_ignore: got cyc=%0d err=%b rdata=%h reads=%0d writes=%0d raddr=%h want 3 0 a1b2c3d4 1 0 00000020",
                     cyc, err, rdata, rdCount - r0, wrCount - w0, lastRdAddr);
        end
        @(negedge clk);
        nCmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nBad++;
            $display("FAIL busy_release: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int cyc; logic e; logic [31:0] rd; int w0;
        w0 = wrCount;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1234;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        nCmp++;
        if (busy !== 1'b0 || MemWrite !== 1'b0 || done !== 1'b0) begin
            nBad++;
            $display("FAIL reset_in_cap: got busy=%b wr=%b done=%b want 0 0 0", busy, MemWrite, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nCmp++;
        if (wrCount != w0) begin
            nBad++;
            $display("FAIL reset_no_write: got writes=%0d want 0", wrCount - w0);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, cyc, e, rd);
        nCmp++;
        if (cyc !== 3 || e !== 1'b0 || rd !== 32'hA1B2C3D4) begin
            nBad++;
            $display("FAIL reset_then_lw: got cyc=%0d err=%b rdata=%h want 3 0 a1b2c3d4", cyc, e, rd);
        end
    endtask

    task automatic test_subword_store();
        int cyc; logic e; logic [31:0] rd; int r0, w0;
        r0 = rdCount; w0 = wrCount;
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFF5A, cyc, e, rd);
        nCmp++;
        if (cyc !== 4 || e !== 1'b0 || rd !== 32'hA1B2C3D4) begin
            nBad++;
            $display("FAIL sb_done: got cyc=%0d err=%b rdata=%h want 4 0 a1b2c3d4", cyc, e, rd);
        end
        nCmp++;
        if (rdCount - r0 != 1 || wrCount - w0 != 1 || lastWrAddr !== 32'h20 || lastWrData !== 32'hA1B25AD4) begin
            nBad++;
            $display("FAIL sb_bus: got reads=%0d writes=%0d addr=%h data=%h want 1 1 00000020 a1b25ad4",
                     rdCount - r0, wrCount - w0, lastWrAddr, lastWrData);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, cyc, e, rd);
        nCmp++;
        if (cyc !== 3 || rd !== 32'hA1B25AD4) begin
            nBad++;
            $display("FAIL sb_readback: got cyc=%0d rdata=%h want 3 a1b25ad4", cyc, rd);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00009876, cyc, e, rd);
        nCmp++;
        if (cyc !== 4 || e !== 1'b0 || lastWrData !== 32'hA1B29876) begin
            nBad++;
            $display("FAIL sh_low: got cyc=%0d err=%b data=%h want 4 0 a1b29876", cyc, e, lastWrData);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, cyc, e, rd);
        nCmp++;
        if (cyc !== 3 || rd !== 32'h00000076) begin
            nBad++;
            $display("FAIL lb_0x23: got cyc=%0d rdata=%h want 3 00000076", cyc, rd);
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_loads();
        test_errors();
        test_busy_ignore();
        test_reset_mid_rmw();
        test_subword_store();
        nCmp++;
        if (bothCount != 0) begin
            nBad++;
            $display("FAIL read_write_overlap: got %0d cycles with both strobes want 0", bothCount);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-cycle CPU's data-memory interface: the master that drives the byte-addressed, big-endian, 128-byte data memory.
- Accepts load/store requests of byte, halfword or word size from the CPU datapath.
- Issues word-aligned MemRead/MemWrite transactions. Sub-word stores use read-modify-write. Load data is extracted and sign/zero-extended.
- Flags misaligned, out-of-range and illegal-size requests without touching memory.

Parameters:
MEM_BYTES, 128, data memory size in bytes; byte addresses >= MEM_BYTES are errors
ADDR_W, 32, width of request and memory address

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous active-high reset
req  input  1  request strobe; sampled only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified for sub-word sizes
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; request rejected, no memory access
rdata  output  32  load result; valid with done, held until next done
MemAddr  output  32  word-aligned address to memory: {addr[31:2],2'b00}
MemWriteData  output  32  word to memory
MemWrite  output  1  memory write strobe
MemRead  output  1  memory read strobe
MemReadData  input  32  memory read data; registered by memory, valid the cycle after MemRead

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, err, MemRead, MemWrite = 0; rdata, MemAddr, MemWriteData = 0.
- All outputs are registered. MemRead and MemWrite are never high in the same cycle.
- Memory byte order is big-endian: byte offset 0 is bits 31:24, offset 3 is bits 7:0. Halfword offset 0 is bits 31:16, offset 2 is bits 15:0.
- Request capture: in IDLE with req=1, latch all req_* fields. req is ignored while busy.
- Error check at capture: size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= MEM_BYTES. On error go to RESP with err=1.
- States: IDLE, RD, CAP, WR, RESP.
- Load: IDLE -> RD (MemRead=1, MemAddr driven) -> CAP (MemReadData valid; extract lane, extend, register into rdata) -> RESP.
- Word store: IDLE -> WR (MemWrite=1, MemWriteData=req_wdata) -> RESP.
- Sub-word store: IDLE -> RD -> CAP (replace the addressed lane of MemReadData with req_wdata[7:0] or [15:0]; all other bytes unchanged) -> WR -> RESP.
- RESP: done=1 for exactly one cycle, then IDLE. Nothing is accepted during RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- Latency, with the accept edge as cycle 0: load done in cycle 3; word store done in cycle 2; sub-word store done in cycle 4; error done in cycle 1.
- err=0 on every successful done. rdata is unchanged on stores and on errors.
- Reset mid-operation returns to IDLE immediately. A pending WR is never issued, so a half-finished RMW leaves memory unmodified.

Test Plan:
- Word store 0xA1B2C3D4 to 0x20, then lw 0x20 -> rdata=0xA1B2C3D4, err=0, done in cycle 3, one MemRead pulse.
- lb 0x21 -> 0xFFFFFFB2; lbu 0x21 -> 0x000000B2; lh 0x22 -> 0xFFFFC3D4; lhu 0x20 -> 0x0000A1B2.
- sb 0x5A at 0x22 over 0xA1B2C3D4 -> memory word 0xA1B25AD4. Exactly one MemRead followed by one MemWrite; done in cycle 4.
- lw 0x21, lh 0x23, size=11 at 0x00, and sw at 0x80 -> each gives done with err=1 in cycle 1, no MemRead/MemWrite, rdata unchanged.
- Assert req during busy with a different address -> ignored; only the first request's transaction appears.
- Assert rst during CAP of sh 0x1234 at 0x20 -> busy=0 immediately, MemWrite never asserted; a following lw 0x20 still returns 0xA1B2C3D4.
